// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with start/done handshake and iterative MULTU/DIVU
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       OP,
   input  logic [WIDTH-1:0] ln1,
   input  logic [WIDTH-1:0] ln2,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             Zero_flag,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   // Opcodes
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0110;
   localparam logic [3:0] OP_AND   = 4'b1000;
   localparam logic [3:0] OP_OR    = 4'b1001;
   localparam logic [3:0] OP_XOR   = 4'b1010;
   localparam logic [3:0] OP_NOR   = 4'b1011;
   localparam logic [3:0] OP_SRL   = 4'b1100;
   localparam logic [3:0] OP_SRA   = 4'b1101;
   localparam logic [3:0] OP_GTU   = 4'b1110;
   localparam logic [3:0] OP_EQ    = 4'b1111;

   // Controller states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [SHW-1:0]   cnt;
   logic             is_div;
   // acc: running product high half / partial remainder
   // lo_q: multiplier shifting out, product low half shifting in / dividend-quotient
   // opb: multiplicand / divisor, held for the whole iteration
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] opb;

   logic             accept;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_ovf;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc_n;
   logic [WIDTH-1:0] mul_lo_n;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_sub;
   logic             div_ge;
   logic [WIDTH-1:0] div_acc_n;
   logic [WIDTH-1:0] div_lo_n;
   logic [WIDTH-1:0] step_acc;
   logic [WIDTH-1:0] step_lo;

   assign ready  = (state != S_RUN);
   assign done   = (state == S_DONE);
   assign accept = start && ready;
   assign shamt  = ln2[SHW-1:0];
   assign sum    = ln1 + ln2;
   assign diff   = ln1 - ln2;

   // Single-cycle result and signed overflow, evaluated on the live operands at accept
   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (OP)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (ln1[WIDTH-1] == ln2[WIDTH-1]) && (sum[WIDTH-1] != ln1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (ln1[WIDTH-1] != ln2[WIDTH-1]) && (diff[WIDTH-1] != ln1[WIDTH-1]);
         end
         OP_AND:  sc_res = ln1 & ln2;
         OP_OR:   sc_res = ln1 | ln2;
         OP_XOR:  sc_res = ln1 ^ ln2;
         OP_NOR:  sc_res = ~(ln1 | ln2);
         OP_SLL:  sc_res = ln1 << shamt;
         OP_SRL:  sc_res = ln1 >> shamt;
         OP_SRA:  sc_res = $signed(ln1) >>> shamt;
         OP_GTU:  sc_res = {{(WIDTH-1){1'b0}}, (ln1 > ln2)};
         OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (ln1 == ln2)};
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(ln1) < $signed(ln2))};
         default: sc_res = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring shift-subtract divide
   always_comb begin
      mul_sum   = {1'b0, acc} + (lo_q[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      mul_acc_n = mul_sum[WIDTH:1];
      mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

      div_sh    = {acc, lo_q[WIDTH-1]};
      div_ge    = (div_sh >= {1'b0, opb});
      div_sub   = div_sh - {1'b0, opb};
      div_acc_n = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
      div_lo_n  = {lo_q[WIDTH-2:0], div_ge};

      step_acc  = is_div ? div_acc_n : mul_acc_n;
      step_lo   = is_div ? div_lo_n  : mul_lo_n;
   end

   // Controller, iteration datapath and output registers (outputs change only on entry to DONE)
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         is_div    <= 1'b0;
         acc       <= '0;
         lo_q      <= '0;
         opb       <= '0;
         result    <= '0;
         hi        <= '0;
         Zero_flag <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (OP == OP_MULTU || (OP == OP_DIVU && ln2 != '0)) begin
                     acc    <= '0;
                     lo_q   <= ln1;
                     opb    <= ln2;
                     is_div <= (OP == OP_DIVU);
                     cnt    <= SHW'(WIDTH - 1);
                     state  <= S_RUN;
                  end else if (OP == OP_DIVU) begin
                     // divide by zero short-cuts the iteration entirely
                     result    <= '1;
                     hi        <= ln1;
                     Zero_flag <= 1'b0;
                     overflow  <= 1'b0;
                     state     <= S_DONE;
                  end else begin
                     result    <= sc_res;
                     hi        <= '0;
                     Zero_flag <= (sc_res == '0);
                     overflow  <= sc_ovf;
                     state     <= S_DONE;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               acc  <= step_acc;
               lo_q <= step_lo;
               if (cnt == '0) begin
                  result    <= step_lo;
                  hi        <= step_acc;
                  Zero_flag <= (step_lo == '0);
                  overflow  <= 1'b0;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven scoreboard bench for alu_seq
module tb_alu_seq;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic        z;
      logic        ov;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        ready;
   logic        done;
   logic [31:0] result;
   logic [31:0] hi;
   logic        zf;
   logic        ovf;

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t sb[$];
   vec_t tbl[$];

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .OP(op), .ln1(a), .ln2(b),
      .ready(ready), .done(done), .result(result), .hi(hi),
      .Zero_flag(zf), .overflow(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] r, input logic [31:0] h, input logic z,
                               input logic v, input int l);
      vec_t t;
      t.op = o; t.a = x; t.b = y; t.res = r; t.hi = h; t.z = z; t.ov = v; t.lat = l;
      return t;
   endfunction

   task automatic compare_done(input int k, input int nrdy);
      vec_t e;
      if (sb.size() == 0) begin
         check("sb_unexpected_done", 1, 0);
         return;
      end
      e = sb.pop_front();
      check($sformatf("res_op%0h", e.op), result, e.res);
      check($sformatf("hi_op%0h", e.op), hi, e.hi);
      check($sformatf("zero_op%0h", e.op), zf, e.z);
      check($sformatf("ovf_op%0h", e.op), ovf, e.ov);
      check($sformatf("latency_op%0h", e.op), k, e.lat);
      check($sformatf("ready_low_op%0h", e.op), nrdy, e.lat - 1);
   endtask

   task automatic run_op(input vec_t v, input bit poke);
      int  nrdy;
      bit  got;
      int  extra;
      @(negedge clk);
      for (int k = 0; k < 50 && !ready; k++) @(negedge clk);
      check("ready_before_start", ready, 1);
      op = v.op; a = v.a; b = v.b; start = 1'b1;
      sb.push_back(v);
      @(posedge clk);
      #1 start = 1'b0;
      nrdy = 0;
      got  = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            compare_done(k, nrdy);
         end else if (!ready) begin
            nrdy++;
         end
         if (poke && !got) begin
            start = (k >= 3 && k <= 6);
            op = 4'b0000; a = $urandom; b = $urandom;
         end
      end
      start = 1'b0;
      if (!got) begin
         check("done_timeout", 0, 1);
         void'(sb.pop_front());
      end
      extra = 0;
      for (int k = 0; k < (poke ? 12 : 1); k++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("no_extra_done", extra, 0);
      check("result_hold", result, v.res);
   endtask

   initial begin
      logic [63:0] prod;
      logic [31:0] x;
      logic [31:0] y;
      int          nd;
      vec_t        e;

      tbl.push_back(mk(4'b0000, 32'd5,          32'd7,          32'd12,         0, 0, 0, 1));
      tbl.push_back(mk(4'b0000, 32'h7FFFFFFF,   32'd1,          32'h80000000,   0, 0, 1, 1));
      tbl.push_back(mk(4'b0001, 32'd3,          32'd3,          32'd0,          0, 1, 0, 1));
      tbl.push_back(mk(4'b0001, 32'h80000000,   32'd1,          32'h7FFFFFFF,   0, 0, 1, 1));
      tbl.push_back(mk(4'b0110, 32'hFFFFFFFF,   32'd1,          32'd1,          0, 0, 0, 1));
      tbl.push_back(mk(4'b0110, 32'd1,          32'hFFFFFFFF,   32'd0,          0, 1, 0, 1));
      tbl.push_back(mk(4'b1110, 32'hFFFFFFFF,   32'd1,          32'd1,          0, 0, 0, 1));
      tbl.push_back(mk(4'b1101, 32'h80000000,   32'h24,         32'hF8000000,   0, 0, 0, 1));
      tbl.push_back(mk(4'b1100, 32'h80000000,   32'h24,         32'h08000000,   0, 0, 0, 1));
      tbl.push_back(mk(4'b0100, 32'd1,          32'd31,         32'h80000000,   0, 0, 0, 1));
      tbl.push_back(mk(4'b1000, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   0, 0, 0, 1));
      tbl.push_back(mk(4'b1001, 32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0,   0, 0, 0, 1));
      tbl.push_back(mk(4'b1010, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   0, 0, 0, 1));
      tbl.push_back(mk(4'b1011, 32'd0,          32'd0,          32'hFFFFFFFF,   0, 0, 0, 1));
      tbl.push_back(mk(4'b1111, 32'd5,          32'd5,          32'd1,          0, 0, 0, 1));
      tbl.push_back(mk(4'b0101, 32'd5,          32'd5,          32'd0,          0, 1, 0, 1));
      tbl.push_back(mk(4'b0011, 32'd100,        32'd7,          32'd14,         2, 0, 0, 33));
      tbl.push_back(mk(4'b0011, 32'd9,          32'd0,          32'hFFFFFFFF,   9, 0, 0, 1));
      for (int i = 0; i < 3; i++) begin
         x = $urandom; y = $urandom;
         prod = 64'(x) * 64'(y);
         tbl.push_back(mk(4'b0010, x, y, prod[31:0], prod[63:32], prod[31:0] == 0, 0, 33));
         y = 32'($urandom_range(1, 32'h0001_FFFF));
         tbl.push_back(mk(4'b0011, x, y, x / y, x % y, (x / y) == 0, 0, 33));
      end

      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_outputs", {result, hi, zf, ovf}, 0);
      reset = 1'b0;

      foreach (tbl[i]) run_op(tbl[i], 1'b0);

      // MULTU with start pulses while busy; only one done may follow
      run_op(mk(4'b0010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 0, 0, 33), 1'b1);

      // back-to-back single-cycle ops, one result per cycle
      @(negedge clk);
      op = 4'b0000; a = 32'd2; b = 32'd3; start = 1'b1;
      sb.push_back(mk(4'b0000, 2, 3, 5, 0, 0, 0, 1));
      @(posedge clk);
      @(negedge clk);
      check("b2b_done1", done, 1);
      if (done) compare_done(1, 0);
      op = 4'b0001; a = 32'd10; b = 32'd30;
      sb.push_back(mk(4'b0001, 10, 30, 32'hFFFFFFEC, 0, 0, 0, 1));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("b2b_done2", done, 1);
      if (done) compare_done(1, 0);
      @(negedge clk);
      check("b2b_idle", done, 0);

      // reset in the middle of a MULTU discards it
      op = 4'b0010; a = 32'h1234; b = 32'h5678; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy", ready, 0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_ready", ready, 1);
      check("mid_rst_done", done, 0);
      check("mid_rst_outputs", {result, hi, zf, ovf}, 0);
      reset = 1'b0;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("mid_rst_no_done", nd, 0);
      run_op(mk(4'b0000, 32'd1, 32'd1, 32'd2, 0, 0, 0, 1), 1'b0);

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
